// File: rtl/net_tx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : net_tx_port_if
//  Description : Producer-side and link-side signal bundle of net_tx_port.
//  Revision    : 1.0  initial release
// ============================================================================
interface net_tx_port_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) ();
    logic [1:0]        src_addr;
    logic [DATA_W-1:0] src_data;
    logic              src_write;
    logic [NUM_CH-1:0] src_full;
    logic              overflow;
    logic [1:0]        to_addr;
    logic [DATA_W:0]   data_to_core;
    logic              valid_back;
    logic [CNT_W-1:0]  tx_count;

    // master: local producer and in_port; slave: the transmitter itself
    modport master (
        output src_addr, src_data, src_write, valid_back,
        input  src_full, overflow, to_addr, data_to_core, tx_count
    );
    modport slave (
        input  src_addr, src_data, src_write, valid_back,
        output src_full, overflow, to_addr, data_to_core, tx_count
    );
endinterface
`default_nettype wire

// File: rtl/net_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : net_tx_port
//  Description : Per-channel FIFOs drained round-robin onto an in_port link.
//  Revision    : 1.0  initial release
// ============================================================================
module net_tx_port #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  wire logic    gclock,
    input  wire logic    reset,
    net_tx_port_if.slave bus
);
    localparam int c_ptr_w = $clog2(DEPTH);

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_nonempty;
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_pop;
    logic [DATA_W-1:0] w_head [NUM_CH];
    logic [1:0]        w_sel;
    logic              w_any;
    logic              w_issue;

    logic [1:0]        r_rr;
    logic [DATA_W:0]   r_data;
    logic [1:0]        r_to_addr;
    logic [CNT_W-1:0]  r_tx_count;
    logic              r_overflow;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DATA_W-1:0]  r_mem [DEPTH];
            logic [c_ptr_w-1:0] r_wr_ptr;
            logic [c_ptr_w-1:0] r_rd_ptr;
            logic [c_ptr_w:0]   r_count;
            logic               w_push;

            // full comes from the registered count, so a same-cycle pop never frees a slot
            assign w_full[c]     = (r_count == (c_ptr_w+1)'(DEPTH));
            assign w_nonempty[c] = (r_count != '0);
            assign w_wr_hit[c]   = bus.src_write && (bus.src_addr == 2'(c));
            assign w_push        = w_wr_hit[c] && !w_full[c];
            assign w_pop[c]      = w_issue && (w_sel == 2'(c));
            assign w_head[c]     = r_mem[r_rd_ptr];

            always_ff @(posedge gclock) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.src_data;
                end
            end

            always_ff @(posedge gclock or posedge reset) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                    end
                    if (w_pop[c]) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                    end
                    if (w_push && !w_pop[c]) begin
                        r_count <= r_count + (c_ptr_w+1)'(1);
                    end else if (!w_push && w_pop[c]) begin
                        r_count <= r_count - (c_ptr_w+1)'(1);
                    end
                end
            end
        end
    endgenerate

    // First non-empty channel at or after the round-robin pointer
    always_comb begin
        int j;
        j     = 0;
        w_sel = '0;
        w_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = (int'(r_rr) + i) % NUM_CH;
            if (!w_any && w_nonempty[j]) begin
                w_any = 1'b1;
                w_sel = 2'(j);
            end
        end
    end

    assign w_issue = w_any && !bus.valid_back;

    always_ff @(posedge gclock or posedge reset) begin
        if (reset) begin
            r_rr       <= '0;
            r_data     <= '0;
            r_to_addr  <= '0;
            r_tx_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_issue) begin
                r_data     <= {1'b1, w_head[w_sel]};
                r_to_addr  <= w_sel;
                r_rr       <= 2'((int'(w_sel) + 1) % NUM_CH);
                r_tx_count <= r_tx_count + CNT_W'(1);
            end else begin
                r_data[DATA_W] <= 1'b0;
            end
            if (|(w_wr_hit & w_full)) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.src_full     = w_full;
    assign bus.overflow     = r_overflow;
    assign bus.to_addr      = r_to_addr;
    assign bus.data_to_core = r_data;
    assign bus.tx_count     = r_tx_count;
endmodule
`default_nettype wire
